spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_pkg.sv | 25 ++
 rtl/spi_reg_bank_if.sv | 32 +++
 rtl/spi_reg_bank_sync_ff.sv | 30 +++
 rtl/spi_reg_bank.sv | 197 +++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg -- shared constants and types for the SPI register bank.
//   FRAME_BITS      : bits in a complete SPI frame (R/W + 7-bit address + 8-bit data)
//   ADDR_*          : register addresses of the five output-stage registers
//   CNT_SAT         : bit-counter saturation value; any count above FRAME_BITS is invalid
//   state_t         : frame FSM states
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_LO    = 7'h02;
    localparam logic [6:0] ADDR_PWM_HI    = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

    localparam int unsigned CNT_W   = 5;
    localparam logic [4:0]  CNT_SAT = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if -- SPI pin bundle between a controller (master) and the
// register bank (slave).
//   sclk_i    : serial clock, mode 0, asynchronous to the system clock
//   copi_i    : controller-out data
//   ncs_i     : chip select, active-low
//   cipo_o    : controller-in data
//   cipo_oe_o : output enable for cipo_o, active-high
interface spi_reg_bank_if;

    logic sclk_i;
    logic copi_i;
    logic ncs_i;
    logic cipo_o;
    logic cipo_oe_o;

    modport master (
        output sclk_i,
        output copi_i,
        output ncs_i,
        input  cipo_o,
        input  cipo_oe_o
    );

    modport slave (
        input  sclk_i,
        input  copi_i,
        input  ncs_i,
        output cipo_o,
        output cipo_oe_o
    );

endinterface

// File: rtl/spi_reg_bank_sync_ff.sv
// sync_ff -- multi-flop synchronizer for one asynchronous input bit.
//   DEPTH   : number of flops in the chain (2 or 3)
//   RST_VAL : value every flop takes in reset (the input's idle level)
//   clk     : destination clock
//   rst_n   : asynchronous reset, active-low
//   d       : asynchronous input
//   q       : synchronized output
module sync_ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank -- SPI (mode 0) slave holding NUM_REGS writable 8-bit registers.
// A 16-bit frame (MSB first: R/W, 7-bit address, 8-bit data) is committed when
// chip select rises, provided exactly 16 bits were clocked, R/W = 1 and the
// address is in range. All SPI inputs are synchronized into clk; requires
// f_clk >= 8 x f_sclk.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   spi            : SPI pins (slave modport)
//   en_reg_out_*   : registers 0x00/0x01
//   en_reg_pwm_*   : registers 0x02/0x03
//   pwm_duty_cycle : register 0x04
// Optional feature: define SPI_READBACK_EN to enable read frames (R/W = 0) that
// shift the addressed register out on cipo_o. Without it cipo_o/cipo_oe_o are 0.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_reg_bank_if.slave  spi,
    output logic [7:0]     en_reg_out_7_0,
    output logic [7:0]     en_reg_out_15_8,
    output logic [7:0]     en_reg_pwm_7_0,
    output logic [7:0]     en_reg_pwm_15_8,
    output logic [7:0]     pwm_duty_cycle
);

    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

    // Synchronized inputs plus one extra flop on sclk/ncs for edge detection
    logic sclk_s, copi_s, ncs_s;
    logic sclk_d, ncs_d;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi.sclk_i), .q(sclk_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(spi.copi_i), .q(copi_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(spi.ncs_i), .q(ncs_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            ncs_d  <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            ncs_d  <= ncs_s;
        end
    end

    logic sclk_rise, ncs_rise, ncs_fall;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    // Frame FSM
    state_t            state, state_next;
    logic [CNT_W-1:0]  count;
    logic [15:0]       shreg;
    logic              fall_pend;
    logic              start, shift_en, commit_wr;
    logic [7:0]        regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        commit_wr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ncs_fall || fall_pend) begin
                    start      = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = sclk_rise & ~ncs_s;
                if (ncs_rise) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit_wr  = (count == 5'(FRAME_BITS)) && shreg[15] &&
                             (shreg[14:8] < NUM_REGS_A);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A chip-select fall seen during COMMIT would be lost when the FSM
    // returns to IDLE; latch it so IDLE starts the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            shreg     <= '0;
            fall_pend <= 1'b0;
        end else begin
            if (state == ST_COMMIT && ncs_fall) begin
                fall_pend <= 1'b1;
            end else if (state == ST_IDLE) begin
                fall_pend <= 1'b0;
            end

            if (start) begin
                count <= '0;
                shreg <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[14:0], copi_s};
                if (count != CNT_SAT) begin
                    count <= count + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (commit_wr && shreg[14:8] == 7'(i)) begin
                    regs[i] <= shreg[7:0];
                end
            end
        end
    end

    assign en_reg_out_7_0  = regs[3'(ADDR_EN_OUT_LO)];
    assign en_reg_out_15_8 = regs[3'(ADDR_EN_OUT_HI)];
    assign en_reg_pwm_7_0  = regs[3'(ADDR_PWM_LO)];
    assign en_reg_pwm_15_8 = regs[3'(ADDR_PWM_HI)];
    assign pwm_duty_cycle  = regs[3'(ADDR_PWM_DUTY)];

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] tx;
    logic       oe;
    logic [6:0] rd_addr;
    logic       rd_load;
    logic [7:0] rd_data;

    assign sclk_fall = ~sclk_s & sclk_d;

    // Header byte as it will be after the 8th bit is shifted in
    assign rd_addr = {shreg[5:0], copi_s};
    assign rd_load = shift_en && (count == 5'd7) && !shreg[6] &&
                     (rd_addr < NUM_REGS_A);

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    // The MSB loaded after the 8th rise must survive the following fall so the
    // controller samples it on the 9th rise; shifting starts after that rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx <= '0;
            oe <= 1'b0;
        end else if (ncs_rise || start) begin
            tx <= '0;
            oe <= 1'b0;
        end else if (rd_load) begin
            tx <= rd_data;
            oe <= 1'b1;
        end else if (oe && sclk_fall && !ncs_s && count >= 5'd9) begin
            tx <= {tx[6:0], 1'b0};
        end
    end

    assign spi.cipo_o    = tx[7];
    assign spi.cipo_oe_o = oe;
`else
    assign spi.cipo_o    = 1'b0;
    assign spi.cipo_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank -- directed self-checking bench for spi_reg_bank.
// Drives SPI frames through the interface (sclk half period = 8 clks) and
// compares register outputs against hand-computed values.
module tb_spi_reg_bank;

    localparam int unsigned SYNC = 2;
    localparam int          HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] r0, r1, r2, r3, r4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_reg_bank_if spi ();

    spi_reg_bank #(
        .SYNC_STAGES(SYNC),
        .NUM_REGS   (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi            (spi),
        .en_reg_out_7_0 (r0),
        .en_reg_out_15_8(r1),
        .en_reg_pwm_7_0 (r2),
        .en_reg_pwm_15_8(r3),
        .pwm_duty_cycle (r4)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        check($sformatf("%s_r0", tag), {8'h00, r0}, {8'h00, e0});
        check($sformatf("%s_r1", tag), {8'h00, r1}, {8'h00, e1});
        check($sformatf("%s_r2", tag), {8'h00, r2}, {8'h00, e2});
        check($sformatf("%s_r3", tag), {8'h00, r3}, {8'h00, e3});
        check($sformatf("%s_r4", tag), {8'h00, r4}, {8'h00, e4});
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends nbits of data MSB first; records cipo/cipo_oe just before each rise.
    // Returns right after chip select is raised.
    task automatic frame(input logic [31:0] data, input int nbits,
                         output logic [15:0] rx, output logic [15:0] oe);
        rx = '0;
        oe = '0;
        spi.ncs_i = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.copi_i = data[i];
            wclk(HALF);
            rx = {rx[14:0], spi.cipo_o};
            oe = {oe[14:0], spi.cipo_oe_o};
            spi.sclk_i = 1'b1;
            wclk(HALF);
            spi.sclk_i = 1'b0;
        end
        wclk(HALF);
        spi.ncs_i  = 1'b1;
        spi.copi_i = 1'b0;
    endtask

    logic [31:0] bits;
    logic [15:0] rx, oe;

    initial begin
        rst_n      = 1'b0;
        spi.sclk_i = 1'b0;
        spi.copi_i = 1'b0;
        spi.ncs_i  = 1'b1;
        wclk(4);
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset_cipo", {15'd0, spi.cipo_o}, 16'h0000);
        check("reset_oe", {15'd0, spi.cipo_oe_o}, 16'h0000);
        rst_n = 1'b1;
        wclk(4);

        // Write 0x80F0 with exact commit latency (SYNC+2 clks after ncs rises)
        frame(32'h80F0, 16, rx, oe);
        repeat (SYNC + 1) @(posedge clk);
        #1 check("w0_early", {8'h00, r0}, 16'h0000);
        @(posedge clk);
        #1 check("w0_latency", {8'h00, r0}, 16'h00F0);
        wclk(16);
        check_regs("w0", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Write duty, then an out-of-range address
        frame(32'h84A5, 16, rx, oe);
        wclk(16);
        check("duty", {8'h00, r4}, 16'h00A5);
        frame(32'h8530, 16, rx, oe);
        wclk(16);
        check_regs("addr5", 8'hF0, 8'h00, 8'h00, 8'h00, 8'hA5);

        // Short frame and over-long frame (last 16 bits form a valid write)
        frame(32'h815, 12, rx, oe);
        wclk(16);
        check("short12", {8'h00, r1}, 16'h0000);
        frame(32'h08155, 20, rx, oe);
        wclk(16);
        check("long20", {8'h00, r1}, 16'h0000);

        // Reset after the 9th bit of 0x82FF
        bits = 32'h82FF;
        spi.ncs_i = 1'b0;
        for (int i = 15; i >= 7; i--) begin
            spi.copi_i = bits[i];
            wclk(HALF);
            spi.sclk_i = 1'b1;
            wclk(HALF);
            spi.sclk_i = 1'b0;
        end
        wclk(2);
        rst_n      = 1'b0;
        spi.ncs_i  = 1'b1;
        spi.copi_i = 1'b0;
        wclk(4);
        check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        wclk(8);
        frame(32'h8233, 16, rx, oe);
        wclk(16);
        check_regs("postrst", 8'h00, 8'h00, 8'h33, 8'h00, 8'h00);

        // Back-to-back with ncs high for one sclk period
        frame(32'h8011, 16, rx, oe);
        wclk(2 * HALF);
        frame(32'h8122, 16, rx, oe);
        wclk(16);
        check("b2b_r0", {8'h00, r0}, 16'h0011);
        check("b2b_r1", {8'h00, r1}, 16'h0022);

        // ncs high for a single clk: the fall lands while the FSM is in COMMIT
        frame(32'h8044, 16, rx, oe);
        wclk(1);
        frame(32'h8166, 16, rx, oe);
        wclk(16);
        check("pend_r0", {8'h00, r0}, 16'h0044);
        check("pend_r1", {8'h00, r1}, 16'h0066);

        // Write 0xC3 to 0x03, then read it back
        frame(32'h83C3, 16, rx, oe);
        wclk(16);
        check("rb_wr", {8'h00, r3}, 16'h00C3);
        frame(32'h0300, 16, rx, oe);
`ifdef SPI_READBACK_EN
        check("rb_data", {8'h00, rx[7:0]}, 16'h00C3);
        check("rb_oe", oe, 16'h00FF);
`else
        check("rb_oe_off", oe, 16'h0000);
        check("rb_cipo_off", rx, 16'h0000);
`endif
        wclk(16);
        check("rb_oe_after", {15'd0, spi.cipo_oe_o}, 16'h0000);
        check_regs("rb_final", 8'h44, 8'h66, 8'h33, 8'hC3, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
